// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem request issue, and a 2-entry
// instruction buffer feeding decode through a valid/ready handshake.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  kill_q, kill_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] buf_instr_q [2];
    logic [DATA_WIDTH-1:0] buf_pc_q    [2];

    logic       pop;
    logic       wr_en;
    logic       issue;
    logic [2:0] credit;
    logic       unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Outstanding work after this cycle's pop; issue only while it leaves room.
    assign pop    = instr_valid & instr_ready;
    assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = !rst && !redirect && (credit < 3'd2);
    assign wr_en  = inflight_q && !kill_q && !redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        kill_d        = redirect;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + FOUR;
        end
        if (redirect) begin
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, wr_en} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(wr_en && count_q == 2'd2));

    assign instr_valid = !rst && (count_q != 2'd0);
    assign instr       = instr_valid ? buf_instr_q[rd_ptr_q] : NOP;
    assign pc          = instr_valid ? buf_pc_q[rd_ptr_q] : '0;
    assign pc_plus4    = pc + FOUR;

endmodule
